subunit_rr_scheduler: RTL and testbench

- Round-robin scheduler that gives exclusive use of one shared resource to one of five sibling sub-units at a time.
- Each sub-unit raises a request; the scheduler grants one, holds the grant until that unit signals done, then moves on.
- A hold-timeout stops a hung sub-unit from starving the others.
- Sits in the parent hierarchy beside the five sub-unit instances.

---
 rtl/subunit_rr_scheduler_pkg.sv | 35 +++
 rtl/subunit_rr_scheduler_pick.sv | 24 ++
 rtl/subunit_rr_scheduler.sv | 103 ++++++++++
 tb/tb_subunit_rr_scheduler.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/subunit_rr_scheduler_pkg.sv
// Shared types and the rotate-priority pick used by the sub-unit round-robin scheduler.
package subunit_rr_scheduler_pkg;

  localparam int DEFAULT_N_REQ = 5;
  localparam int MAX_REQ       = 8;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First set bit strictly after 'last', wrapping modulo n_req; 'last' itself is checked last.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                       input logic [2:0]         last,
                                       input int                 n_req);
    rr_pick_t res;
    int       idx;
    res = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = (int'(last) + k) % n_req;
      if (k <= n_req && !res.found && req[idx]) begin
        res.found = 1'b1;
        res.idx   = idx[2:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/subunit_rr_scheduler_pick.sv
// Combinational rotate-priority encoder: picks the next requester after the last one served.
module subunit_rr_pick
  import subunit_rr_scheduler_pkg::*;
#(
  parameter int N_REQ = DEFAULT_N_REQ,
  parameter int ID_W  = 3
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic [ID_W-1:0]  sel,
  output logic             found
);

  logic [MAX_REQ-1:0] req_ext;
  logic [2:0]         last_ext;
  rr_pick_t           pick;

  assign req_ext  = MAX_REQ'(req);
  assign last_ext = 3'(last);
  assign pick     = rr_pick(req_ext, last_ext, N_REQ);
  assign sel      = ID_W'(pick.idx);
  assign found    = pick.found;

endmodule

// File: rtl/subunit_rr_scheduler.sv
// Round-robin owner of a shared resource across sibling sub-units, with a hold timeout.
//
//   state | meaning
//   IDLE  | no grant; pick next requester after 'last'
//   GRANT | one unit owns the resource; wait for done, withdraw or hold limit
//   GAP   | one dead cycle after release before the next pick
module subunit_rr_scheduler
  import subunit_rr_scheduler_pkg::*;
#(
  parameter int N_REQ    = DEFAULT_N_REQ,
  parameter int MAX_HOLD = 16,
  parameter int ID_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             busy,
  output logic             timeout
);

  localparam int              CNT_W     = $clog2(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MAX_HOLD - 1);
  localparam logic [ID_W-1:0]  LAST_INIT = ID_W'(N_REQ - 1);

  state_t           state, state_nxt;
  logic [N_REQ-1:0] grant_nxt;
  logic [ID_W-1:0]  grant_id_nxt, last, last_nxt, sel;
  logic             busy_nxt, timeout_nxt, found;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             own_done, own_req, at_limit;

  subunit_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req   (req),
    .last  (last),
    .sel   (sel),
    .found (found)
  );

  // Only the granted unit's done/req bits matter; everything else is ignored.
  assign own_done = done[grant_id];
  assign own_req  = req[grant_id];
  assign at_limit = (cnt == CNT_LAST);

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    grant_id_nxt = grant_id;
    busy_nxt     = busy;
    timeout_nxt  = 1'b0;
    last_nxt     = last;
    cnt_nxt      = cnt;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt    = GRANT;
          grant_nxt    = N_REQ'(1) << sel;
          grant_id_nxt = sel;
          busy_nxt     = 1'b1;
          last_nxt     = sel;
          cnt_nxt      = '0;
        end
      end
      GRANT: begin
        if (!at_limit) cnt_nxt = cnt + CNT_W'(1);
        if (own_done || !own_req || at_limit) begin
          state_nxt   = GAP;
          grant_nxt   = '0;
          busy_nxt    = 1'b0;
          timeout_nxt = !own_done && own_req;
        end
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      last     <= LAST_INIT;
      cnt      <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      grant_id <= grant_id_nxt;
      busy     <= busy_nxt;
      timeout  <= timeout_nxt;
      last     <= last_nxt;
      cnt      <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_subunit_rr_scheduler.sv
// Scoreboard bench for subunit_rr_scheduler: expected grant ids queued with stimulus, popped on each grant.
module tb_subunit_rr_scheduler;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req, done, grant;
  logic [2:0]   grant_id;
  logic         busy, timeout;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  subunit_rr_scheduler #(
    .N_REQ    (N),
    .MAX_HOLD (16),
    .ID_W     (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .done     (done),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .timeout  (timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic wait_grant(output int cyc);
    cyc = 0;
    while (grant == '0 && cyc < 100) begin
      tick;
      cyc++;
    end
    check("grant_seen", 32'(|grant), 1);
  endtask

  task automatic score;
    int e;
    check("sb_nonempty", 32'(exp_q.size() != 0), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("grant_id", 32'(grant_id), e);
      check("grant_onehot", 32'(grant), 32'(1) << e);
      check("busy_on_grant", 32'(busy), 1);
    end
  endtask

  task automatic check_released(input string tag, input logic exp_to);
    check({tag, "_grant"}, 32'(grant), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_timeout"}, 32'(timeout), 32'(exp_to));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, hold;
    rst  = 1'b1;
    req  = '0;
    done = '0;
    tick;
    tick;
    check("rst_grant", 32'(grant), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_timeout", 32'(timeout), 0);
    rst = 1'b0;

    // single requester, done three cycles into the grant
    req = 5'b00100;
    exp_q.push_back(2);
    wait_grant(cyc);
    check("s1_latency", cyc, 1);
    score();
    repeat (3) begin
      tick;
      check("s1_hold_id", 32'(grant_id), 2);
      check("s1_hold_grant", 32'(grant), 32'(5'b00100));
    end
    done = 5'b00100;
    tick;
    check_released("s1_release", 1'b0);
    done = '0;
    req  = '0;
    tick;
    check("s1_gap", 32'(grant), 0);
    tick;

    // all requesting, immediate done: strict rotation with two idle cycles between grants
    do_reset();
    req = 5'b11111;
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(4); exp_q.push_back(0);
    for (int i = 0; i < 6; i++) begin
      wait_grant(cyc);
      check(i == 0 ? "s2_first_latency" : "s2_gap_cycles", cyc, i == 0 ? 1 : 2);
      score();
      done = grant;
      tick;
      check_released("s2_release", 1'b0);
      done = '0;
    end
    req = '0;
    tick;
    tick;

    // wrap-around: after unit 3, unit 0 goes before unit 3 again
    req = 5'b01000;
    exp_q.push_back(3);
    wait_grant(cyc);
    score();
    done = 5'b01000;
    tick;
    done = '0;
    req  = 5'b01001;
    exp_q.push_back(0);
    exp_q.push_back(3);
    repeat (2) begin
      wait_grant(cyc);
      score();
      done = grant;
      tick;
      done = '0;
    end
    req = '0;
    tick;
    tick;

    // hung unit: forced release after 16 grant cycles, single timeout pulse, then re-grant
    req = 5'b00010;
    exp_q.push_back(1);
    exp_q.push_back(1);
    wait_grant(cyc);
    score();
    check("s4_to_start", 32'(timeout), 0);
    hold = 1;
    while (grant != '0 && hold < 40) begin
      tick;
      if (grant != '0) begin
        hold++;
        check("s4_to_low", 32'(timeout), 0);
      end
    end
    check("s4_hold_cycles", hold, 16);
    check_released("s4_forced", 1'b1);
    tick;
    check("s4_to_once", 32'(timeout), 0);
    wait_grant(cyc);
    check("s4_regrant_latency", cyc, 1);
    score();
    req = '0;
    tick;
    check_released("s4_withdraw", 1'b0);
    tick;
    tick;

    // foreign done ignored; release by withdraw without timeout
    req = 5'b10000;
    exp_q.push_back(4);
    wait_grant(cyc);
    score();
    done = 5'b00010;
    tick;
    check("s5_foreign_done", 32'(grant), 32'(5'b10000));
    req = '0;
    tick;
    check_released("s5_withdraw", 1'b0);
    done = '0;
    tick;
    tick;

    // reset mid-grant, then unit 0 first again
    req = 5'b01000;
    exp_q.push_back(3);
    wait_grant(cyc);
    score();
    rst = 1'b1;
    tick;
    check_released("s6_reset", 1'b0);
    rst = 1'b0;
    req = 5'b11111;
    exp_q.push_back(0);
    wait_grant(cyc);
    check("s6_latency", cyc, 1);
    score();
    done = grant;
    tick;
    done = '0;
    req  = '0;
    tick;

    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
